speck_encrypt_ctrl: RTL and testbench

Iterative Speck128/128 encryption controller. It accepts one 128-bit plaintext block and a 128-bit key over a valid/ready handshake. It runs all 32 rounds through a single shared round-function sub-module, time-multiplexing data rounds with on-the-fly key-schedule rounds, and returns the ciphertext with a one-cycle done pulse. It sits between the cipher top level and the round datapath, and replaces per-round external sequencing.

---
 rtl/speck_pkg.sv | 31 +++
 rtl/speck_encrypt_ctrl_if.sv | 28 ++
 rtl/speck_round.sv | 23 ++
 rtl/speck_encrypt_ctrl.sv | 99 +++++++++
 tb/tb_speck_encrypt_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/speck_pkg.sv
`default_nettype none
// ============================================================================
// speck_pkg : shared Speck128/128 constants, FSM state type, rotate helpers
// Rev 1.0
// ============================================================================
package speck_pkg;

  localparam int WORD_W    = 64;
  localparam int ROUNDS    = 32;
  localparam int ROT_ALPHA = 8;
  localparam int ROT_BETA  = 3;
  localparam int BLOCK_W   = 2 * WORD_W;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_KEY  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] ror_w(input logic [WORD_W-1:0] v, input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rol_w(input logic [WORD_W-1:0] v, input int n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/speck_encrypt_ctrl_if.sv
`default_nettype none
// ============================================================================
// speck_encrypt_ctrl_if : start handshake, key/plaintext in, ciphertext/status out
// Rev 1.0
// ============================================================================
interface speck_encrypt_ctrl_if;
  import speck_pkg::*;

  logic               start_valid;
  logic               start_ready;
  logic [BLOCK_W-1:0] key;
  logic [BLOCK_W-1:0] plaintext;
  logic [BLOCK_W-1:0] ciphertext;
  logic               done;
  logic               busy;
  logic [CNT_W-1:0]   round_cnt;

  modport master (
    output start_valid, key, plaintext,
    input  start_ready, ciphertext, done, busy, round_cnt
  );

  modport slave (
    input  start_valid, key, plaintext,
    output start_ready, ciphertext, done, busy, round_cnt
  );
endinterface
`default_nettype wire

// File: rtl/speck_round.sv
`default_nettype none
// ============================================================================
// speck_round : combinational Speck round R(a,b,c), shared by data and key rounds
// Rev 1.0
// ============================================================================
module speck_round
  import speck_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic [WORD_W-1:0] c_i,
  output logic [WORD_W-1:0] a_o,
  output logic [WORD_W-1:0] b_o
);

  logic [WORD_W-1:0] a_new;

  assign a_new = (ror_w(a_i, ROT_ALPHA) + b_i) ^ c_i;
  assign a_o   = a_new;
  assign b_o   = rol_w(b_i, ROT_BETA) ^ a_new;

endmodule
`default_nettype wire

// File: rtl/speck_encrypt_ctrl.sv
`default_nettype none
// ============================================================================
// speck_encrypt_ctrl : iterative Speck128/128 encryptor, data and key-schedule
// rounds interleaved through one round instance. Rev 1.0
// ============================================================================
module speck_encrypt_ctrl
  import speck_pkg::*;
#(
  parameter int ROUNDS = speck_pkg::ROUNDS,
  parameter int WORD_W = speck_pkg::WORD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  speck_encrypt_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_e              state_q;
  logic [WORD_W-1:0]   x_q, y_q, k_q, l_q;
  logic [CNT_W-1:0]    i_q;
  logic [2*WORD_W-1:0] ct_q;
  logic                done_q;

  logic [WORD_W-1:0]   op_a, op_b, op_c;
  logic [WORD_W-1:0]   rnd_a_d, rnd_b_d;

  // KEY state reuses the round with (l, k, i); every other state feeds (x, y, k)
  always_comb begin
    op_a = x_q;
    op_b = y_q;
    op_c = k_q;
    if (state_q == ST_KEY) begin
      op_a = l_q;
      op_b = k_q;
      op_c = WORD_W'(i_q);
    end
  end

  speck_round u_round (
    .a_i (op_a),
    .b_i (op_b),
    .c_i (op_c),
    .a_o (rnd_a_d),
    .b_o (rnd_b_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      l_q     <= '0;
      i_q     <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_valid) begin
            y_q     <= bus.plaintext[2*WORD_W-1:WORD_W];
            x_q     <= bus.plaintext[WORD_W-1:0];
            l_q     <= bus.key[2*WORD_W-1:WORD_W];
            k_q     <= bus.key[WORD_W-1:0];
            i_q     <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          x_q     <= rnd_a_d;
          y_q     <= rnd_b_d;
          state_q <= (i_q == LAST_RND) ? ST_DONE : ST_KEY;
        end
        ST_KEY: begin
          l_q     <= rnd_a_d;
          k_q     <= rnd_b_d;
          i_q     <= i_q + 1'b1;
          state_q <= ST_DATA;
        end
        ST_DONE: begin
          ct_q    <= {y_q, x_q};
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.ciphertext  = ct_q;
  assign bus.done        = done_q;
  assign bus.round_cnt   = i_q;

endmodule
`default_nettype wire

// File: tb/tb_speck_encrypt_ctrl.sv
`default_nettype none
// ============================================================================
// tb_speck_encrypt_ctrl : directed + random checks against a Speck128/128 model
// Rev 1.0
// ============================================================================
module tb_speck_encrypt_ctrl;

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_PT  = 128'h7469206564616d20_6c61766975716520;
  localparam logic [127:0] KAT_CT  = 128'h7860fedf5c570d18_a65d985179783265;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  speck_encrypt_ctrl_if bus ();

  speck_encrypt_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: straight Speck128/128 key expansion interleaved with encryption
  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [63:0] x, y, k, l;
    x = pt[63:0];
    y = pt[127:64];
    k = key[63:0];
    l = key[127:64];
    for (int r = 0; r < 32; r++) begin
      x = ({x[7:0], x[63:8]} + y) ^ k;
      y = {y[60:0], y[63:61]} ^ x;
      if (r < 31) begin
        l = ({l[7:0], l[63:8]} + k) ^ 64'(r);
        k = {k[60:0], k[63:61]} ^ l;
      end
    end
    return {y, x};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the negedge right after the accept edge.
  task automatic launch(input logic [127:0] k, input logic [127:0] pt, input bit hold);
    bus.key         = k;
    bus.plaintext   = pt;
    bus.start_valid = 1'b1;
    chk("ready_before_accept", 128'(bus.start_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start_valid = 1'b0;
  endtask

  // Follows one operation from the cycle after accept (n=0) to the cycle after T+64.
  task automatic track_op(input logic [127:0] exp_ct, input bit perturb);
    int busy_err = 0;
    int cnt_err  = 0;
    for (int n = 0; n < 64; n++) begin
      if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0 || bus.done !== 1'b0) busy_err++;
      if (n < 63 && bus.round_cnt !== 5'(n / 2)) cnt_err++;
      if (perturb && n == 10) begin
        bus.start_valid = 1'b1;
        bus.key         = rand128();
        bus.plaintext   = rand128();
      end else if (perturb && n == 13) begin
        bus.start_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("busy_window", 128'(busy_err), 128'd0);
    chk("round_cnt_trace", 128'(cnt_err), 128'd0);
    chk("done_pulse", 128'(bus.done), 128'd1);
    chk("ciphertext", bus.ciphertext, exp_ct);
    chk("busy_after_done", 128'(bus.busy), 128'd0);
    chk("ready_after_done", 128'(bus.start_ready), 128'd1);
  endtask

  task automatic post_op(input logic [127:0] exp_ct);
    @(negedge clk);
    chk("done_single_cycle", 128'(bus.done), 128'd0);
    chk("no_extra_accept", 128'(bus.busy), 128'd0);
    chk("ciphertext_hold", bus.ciphertext, exp_ct);
  endtask

  initial begin
    logic [127:0] k0, p0;
    int done_seen;

    bus.start_valid = 1'b0;
    bus.key         = '0;
    bus.plaintext   = '0;

    // asynchronous reset, checked before any clock edge samples it
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", 128'(bus.start_ready), 128'd1);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_ciphertext", bus.ciphertext, 128'd0);
    chk("rst_round_cnt", 128'(bus.round_cnt), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // known-answer vector
    chk("model_kat", ref_encrypt(KAT_KEY, KAT_PT), KAT_CT);
    launch(KAT_KEY, KAT_PT, 1'b0);
    track_op(KAT_CT, 1'b0);
    post_op(KAT_CT);

    // back-to-back with start_valid held high
    launch(KAT_KEY, KAT_PT, 1'b1);
    track_op(KAT_CT, 1'b0);
    @(negedge clk);
    bus.start_valid = 1'b0;
    track_op(KAT_CT, 1'b0);
    post_op(KAT_CT);

    // input changes and start pulses while busy must be ignored
    k0 = rand128();
    p0 = rand128();
    launch(k0, p0, 1'b0);
    track_op(ref_encrypt(k0, p0), 1'b1);
    post_op(ref_encrypt(k0, p0));

    // random vectors
    for (int t = 0; t < 3; t++) begin
      k0 = rand128();
      p0 = rand128();
      launch(k0, p0, 1'b0);
      track_op(ref_encrypt(k0, p0), 1'b0);
      post_op(ref_encrypt(k0, p0));
    end

    // reset mid-operation at T+30
    launch(KAT_KEY, KAT_PT, 1'b0);
    repeat (29) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 128'(bus.start_ready), 128'd1);
    chk("abort_busy", 128'(bus.busy), 128'd0);
    chk("abort_round_cnt", 128'(bus.round_cnt), 128'd0);
    chk("abort_ciphertext", bus.ciphertext, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 70; n++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 128'(done_seen), 128'd0);
    launch(KAT_KEY, KAT_PT, 1'b0);
    track_op(KAT_CT, 1'b0);
    post_op(KAT_CT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
